dbus_ram_bridge: RTL and testbench

Downstream consumer of the CPU data bus (dBus cmd/rsp, VexRiscv-style) that buffers commands in a 2-entry FIFO and turns them into byte-enabled accesses on a single-port, 1-cycle-latency data RAM. It returns read data on the dBus response channel and produces no response for writes. It sits between the CPU wrapper and the data RAM / RAM arbiter in the cosim SoC.

---
 rtl/dbus_pkg.sv | 30 +++
 rtl/dbus_cmd_fifo.sv | 51 +++++
 rtl/dbus_ram_bridge.sv | 128 ++++++++++++
 tb/tb_dbus_ram_bridge.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared dBus definitions: size encodings, command bundle, byte-enable helper.
package dbus_pkg;

  localparam logic [1:0] DBUS_SIZE_B = 2'd0;
  localparam logic [1:0] DBUS_SIZE_H = 2'd1;
  localparam logic [1:0] DBUS_SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } dbus_cmd_t;

  // Size 3 falls through to a full-word enable.
  function automatic logic [3:0] dbus_be(
    input logic [1:0] size,
    input logic [1:0] addr_lsb
  );
    logic [3:0] be;
    case (size)
      DBUS_SIZE_B: be = 4'b0001 << addr_lsb;
      DBUS_SIZE_H: be = addr_lsb[1] ? 4'b1100 : 4'b0011;
      DBUS_SIZE_W: be = 4'b1111;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dbus_cmd_fifo.sv
// Two-entry synchronous FIFO for decoded dBus commands.
module dbus_cmd_fifo #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q, wptr_d;
  logic          rptr_q, rptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign rdata_o = mem_q[rptr_q];

  // A full FIFO never takes a push, even alongside a pop.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q ^ do_push;
    rptr_d = rptr_q ^ do_pop;
    cnt_d  = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dbus_ram_bridge.sv
// dBus command/response to single-port data RAM bridge with 2-entry buffer.
// Define DBUS_RAM_BRIDGE_ERR_EN to enable size/alignment/range error checks.
module dbus_ram_bridge
  import dbus_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk_cpu,
  input  logic              clk_cpu_reset,
  input  logic              dBus_cmd_valid,
  output logic              dBus_cmd_ready,
  input  logic              dBus_cmd_payload_wr,
  input  logic [31:0]       dBus_cmd_payload_address,
  input  logic [31:0]       dBus_cmd_payload_data,
  input  logic [1:0]        dBus_cmd_payload_size,
  output logic              dBus_rsp_ready,
  output logic              dBus_rsp_error,
  output logic [31:0]       dBus_rsp_data,
  output logic              ram_req,
  input  logic              ram_ready,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              err_sticky
);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
    logic              err;
  } ent_t;

  dbus_cmd_t   cmd;
  ent_t        in_e, head, fifo_head;
  logic [31:0] off;
  logic        full, empty;
  logic        accept, head_vld, issue, push, pop;
  logic        rd_pend_q, rd_pend_d;
  logic        rsp_err_q, rsp_err_d;
  logic        sticky_q, sticky_d;
  logic [31:0] hold_q, hold_d;

  assign cmd = '{wr:   dBus_cmd_payload_wr,
                 addr: dBus_cmd_payload_address,
                 data: dBus_cmd_payload_data,
                 size: dBus_cmd_payload_size};

  assign off = cmd.addr - BASE_ADDR;

  always_comb begin
    in_e      = '0;
    in_e.wr   = cmd.wr;
    in_e.addr = ADDR_W'(off >> 2);
    in_e.be   = dbus_be(cmd.size, cmd.addr[1:0]);
    in_e.data = cmd.data;
`ifdef DBUS_RAM_BRIDGE_ERR_EN
    case (cmd.size)
      DBUS_SIZE_B: in_e.err = 1'b0;
      DBUS_SIZE_H: in_e.err = cmd.addr[0];
      DBUS_SIZE_W: in_e.err = |cmd.addr[1:0];
      default:     in_e.err = 1'b1;
    endcase
    if ((off >> (ADDR_W + 2)) != 32'd0) in_e.err = 1'b1;
`else
    in_e.err  = 1'b0;
`endif
  end

  dbus_cmd_fifo #(.DW($bits(ent_t))) u_fifo (
    .clk_i   (clk_cpu),
    .rst_i   (clk_cpu_reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_e),
    .rdata_o (fifo_head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign dBus_cmd_ready = ~full;
  assign accept         = dBus_cmd_valid & dBus_cmd_ready;

  // Empty FIFO: the incoming command is presented directly (bypass).
  assign head     = empty ? in_e : fifo_head;
  assign head_vld = accept | ~empty;
  assign issue    = head_vld & (ram_ready | head.err);
  assign push     = accept & ~(empty & issue);
  assign pop      = issue & ~empty;

  assign ram_req   = head_vld & ~head.err;
  assign ram_wr    = ram_req & head.wr;
  assign ram_be    = ram_req ? head.be : 4'b0000;
  assign ram_addr  = head.addr;
  assign ram_wdata = head.data;

  always_comb begin
    rd_pend_d = issue & ~head.wr;
    rsp_err_d = head.err;
    sticky_d  = sticky_q | (issue & head.err);
    hold_d    = dBus_rsp_data;
  end

  assign dBus_rsp_ready = rd_pend_q;
  assign dBus_rsp_error = rd_pend_q & rsp_err_q;
  assign dBus_rsp_data  = rd_pend_q ? (rsp_err_q ? 32'd0 : ram_rdata)
                                    : hold_q;
  assign err_sticky     = sticky_q;

  always_ff @(posedge clk_cpu or posedge clk_cpu_reset) begin
    if (clk_cpu_reset) begin
      rd_pend_q <= 1'b0;
      rsp_err_q <= 1'b0;
      sticky_q  <= 1'b0;
      hold_q    <= 32'd0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rsp_err_q <= rsp_err_d;
      sticky_q  <= sticky_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_dbus_ram_bridge.sv
// Directed testbench for dbus_ram_bridge with a behavioural 1-cycle RAM.
// Error-path steps follow DBUS_RAM_BRIDGE_ERR_EN.
module tb_dbus_ram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, cmd_ready, wr;
  logic [31:0] addr, data;
  logic [1:0]  size;
  logic        rsp_ready, rsp_error;
  logic [31:0] rsp_data;
  logic        ram_req, ram_ready, ram_wr;
  logic [11:0] ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;
  logic        err_sticky;

  logic [31:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;
  int          pulses;

  always #5 clk = ~clk;

  dbus_ram_bridge dut (
    .clk_cpu                  (clk),
    .clk_cpu_reset            (rst),
    .dBus_cmd_valid           (valid),
    .dBus_cmd_ready           (cmd_ready),
    .dBus_cmd_payload_wr      (wr),
    .dBus_cmd_payload_address (addr),
    .dBus_cmd_payload_data    (data),
    .dBus_cmd_payload_size    (size),
    .dBus_rsp_ready           (rsp_ready),
    .dBus_rsp_error           (rsp_error),
    .dBus_rsp_data            (rsp_data),
    .ram_req                  (ram_req),
    .ram_ready                (ram_ready),
    .ram_wr                   (ram_wr),
    .ram_addr                 (ram_addr),
    .ram_be                   (ram_be),
    .ram_wdata                (ram_wdata),
    .ram_rdata                (ram_rdata),
    .err_sticky               (err_sticky)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
      ram_rdata <= 32'd0;
    end else if (ram_req && ram_ready) begin
      if (ram_wr) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string t, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] s,
                       input logic rr);
    @(negedge clk);
    valid = v; wr = w; addr = a; data = d; size = s; ram_ready = rr;
    #1;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; wr = 1'b0; addr = '0; data = '0;
    size = 2'd2; ram_ready = 1'b0;
    @(negedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_ram_req", ram_req, 1'b0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_ram_be", ram_be, 4'h0);
    chk("rst_rsp_ready", rsp_ready, 1'b0);
    chk("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_err_sticky", err_sticky, 1'b0);
    @(negedge clk); rst = 1'b0;

    drive(1, 1, 32'h10, 32'h1234_5678, 2'd2, 1);
    chk("ww_req", ram_req, 1'b1);
    chk("ww_wr", ram_wr, 1'b1);
    chk("ww_be", ram_be, 4'hF);
    chk("ww_addr", ram_addr, 12'd4);
    chk("ww_wdata", ram_wdata, 32'h1234_5678);
    drive(1, 0, 32'h10, 32'h0, 2'd2, 1);
    chk("ww_no_rsp", rsp_ready, 1'b0);
    chk("wr_be", ram_be, 4'hF);
    chk("wr_addr", ram_addr, 12'd4);
    chk("wr_wr", ram_wr, 1'b0);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("wr_rsp_ready", rsp_ready, 1'b1);
    chk("wr_rsp_data", rsp_data, 32'h1234_5678);
    chk("wr_rsp_error", rsp_error, 1'b0);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("wr_rsp_gone", rsp_ready, 1'b0);
    chk("wr_rsp_hold", rsp_data, 32'h1234_5678);

    drive(1, 1, 32'h3, 32'hAB00_0000, 2'd0, 1);
    chk("b3_be", ram_be, 4'b1000);
    drive(1, 1, 32'h2, 32'hCDEF_0000, 2'd1, 1);
    chk("h2_be", ram_be, 4'b1100);
    chk("b3_no_rsp", rsp_ready, 1'b0);
    drive(1, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("h2_no_rsp", rsp_ready, 1'b0);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("w0_rsp_ready", rsp_ready, 1'b1);
    chk("w0_rsp_data", rsp_data, 32'hCDEF_0000);

    for (int i = 1; i <= 3; i++)
      drive(1, 1, 32'(4 * i), 32'h1111_1111 * i, 2'd2, 1);

    drive(1, 0, 32'h4, 32'h0, 2'd2, 0);
    chk("bp_ready0", cmd_ready, 1'b1);
    chk("bp_req0", ram_req, 1'b1);
    drive(1, 0, 32'h8, 32'h0, 2'd2, 0);
    chk("bp_ready1", cmd_ready, 1'b1);
    chk("bp_head1", ram_addr, 12'd1);
    drive(1, 0, 32'hC, 32'h0, 2'd2, 0);
    chk("bp_full", cmd_ready, 1'b0);
    drive(1, 0, 32'hC, 32'h0, 2'd2, 0);
    chk("bp_full_hold", cmd_ready, 1'b0);
    chk("bp_no_rsp", rsp_ready, 1'b0);
    chk("bp_head_hold", ram_addr, 12'd1);
    drive(1, 0, 32'hC, 32'h0, 2'd2, 1);
    chk("bp_rel_full", cmd_ready, 1'b0);
    drive(1, 0, 32'hC, 32'h0, 2'd2, 1);
    chk("bp_rsp1", rsp_ready, 1'b1);
    chk("bp_rsp1_data", rsp_data, 32'h1111_1111);
    chk("bp_accept3", cmd_ready, 1'b1);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("bp_rsp2", rsp_ready, 1'b1);
    chk("bp_rsp2_data", rsp_data, 32'h2222_2222);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("bp_rsp3", rsp_ready, 1'b1);
    chk("bp_rsp3_data", rsp_data, 32'h3333_3333);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("bp_done", rsp_ready, 1'b0);

    drive(1, 0, 32'h4, 32'h0, 2'd2, 0);
    drive(1, 0, 32'h8, 32'h0, 2'd2, 0);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    #1;
    chk("mr_ready_in_rst", cmd_ready, 1'b1);
    chk("mr_req_in_rst", ram_req, 1'b0);
    @(negedge clk);
    rst = 1'b0; ram_ready = 1'b1;
    #1;
    chk("mr_ready_after", cmd_ready, 1'b1);
    chk("mr_req_after", ram_req, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
      pulses += int'(rsp_ready);
    end
    chk("mr_no_pulses", pulses, 0);

    drive(1, 1, 32'h0, 32'hCDEF_0000, 2'd2, 1);

`ifdef DBUS_RAM_BRIDGE_ERR_EN
    drive(1, 0, 32'h2, 32'h0, 2'd2, 0);
    chk("er_no_req", ram_req, 1'b0);
    chk("er_sticky_pre", err_sticky, 1'b0);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 0);
    chk("er_rsp_ready", rsp_ready, 1'b1);
    chk("er_rsp_error", rsp_error, 1'b1);
    chk("er_rsp_data", rsp_data, 32'h0);
    chk("er_sticky", err_sticky, 1'b1);
    drive(1, 1, 32'h4000, 32'hDEAD_BEEF, 2'd2, 1);
    chk("oor_no_req", ram_req, 1'b0);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("oor_no_rsp", rsp_ready, 1'b0);
    chk("oor_mem0", mem[0], 32'hCDEF_0000);
`else
    drive(1, 0, 32'h2, 32'h0, 2'd2, 1);
    chk("ne_req", ram_req, 1'b1);
    chk("ne_be", ram_be, 4'hF);
    chk("ne_addr", ram_addr, 12'd0);
    drive(0, 0, 32'h0, 32'h0, 2'd2, 1);
    chk("ne_rsp_ready", rsp_ready, 1'b1);
    chk("ne_rsp_error", rsp_error, 1'b0);
    chk("ne_rsp_data", rsp_data, 32'hCDEF_0000);
    chk("ne_sticky", err_sticky, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
